// File: rtl/axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_wr_arbiter
//   Shares one downstream AXI write slave among NUM_MST upstream masters.
//   AW requests are granted round-robin. The winner keeps the grant through
//   its whole W burst, which ends on WLAST, and then the bus is re-arbitrated.
//   Each accepted AW pushes the winner's index into an in-order queue. B
//   responses are steered to the master at the head of that queue, and the
//   entry is popped on the B handshake.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   m_awvalid/m_awready             per-master AW handshake
//   m_awaddr/m_awlen                packed per-master AW payload
//   m_wvalid/m_wready               per-master W handshake
//   m_wdata/m_wlast                 packed per-master W payload
//   m_bvalid/m_bready/m_bresp       per-master B channel
//   s_aw*/s_w*/s_b*                 single downstream slave AW/W/B channels
// -----------------------------------------------------------------------------
module axi_wr_arbiter #(
    parameter int NUM_MST     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_MST-1:0]               m_awvalid,
    output logic [NUM_MST-1:0]               m_awready,
    input  logic [NUM_MST*ADDR_WIDTH-1:0]    m_awaddr,
    input  logic [NUM_MST*8-1:0]             m_awlen,
    input  logic [NUM_MST-1:0]               m_wvalid,
    output logic [NUM_MST-1:0]               m_wready,
    input  logic [NUM_MST*DATA_WIDTH-1:0]    m_wdata,
    input  logic [NUM_MST-1:0]               m_wlast,
    output logic [NUM_MST-1:0]               m_bvalid,
    input  logic [NUM_MST-1:0]               m_bready,
    output logic [NUM_MST*2-1:0]             m_bresp,
    output logic                             s_awvalid,
    input  logic                             s_awready,
    output logic [ADDR_WIDTH-1:0]            s_awaddr,
    output logic [7:0]                       s_awlen,
    output logic                             s_wvalid,
    input  logic                             s_wready,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic                             s_wlast,
    input  logic                             s_bvalid,
    output logic                             s_bready,
    input  logic [1:0]                       s_bresp
);

    localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [IW-1:0] LAST_MST = IW'(NUM_MST - 1);
    localparam logic [PW-1:0] PTR_MAX  = PW'(OUTSTANDING - 1);

    typedef enum logic [1:0] {ARB, ADDR, DATA} state_t;

    state_t        state;
    logic [IW-1:0] grant;
    logic [IW-1:0] last_grant;

    // In-order queue of masters awaiting a B response
    logic [IW-1:0] q_mem [OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_wrap;
    logic          rd_wrap;
    logic          q_full;
    logic          q_empty;
    logic          push;
    logic          pop;
    logic [IW-1:0] head;

    logic          arb_found;
    logic [IW-1:0] arb_pick;
    logic [IW-1:0] cand;

    // Pointers are equal both when the queue is full and when it is empty.
    // The wrap bits tell the two cases apart.
    assign q_full  = (wr_ptr == rd_ptr) && (wr_wrap != rd_wrap);
    assign q_empty = (wr_ptr == rd_ptr) && (wr_wrap == rd_wrap);
    assign head    = q_mem[rd_ptr];

    assign push = (state == ADDR) && s_awvalid && s_awready;
    assign pop  = s_bvalid && s_bready;

    // Round-robin pick: scan starting just after the previous winner
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_MST);
            if (!arb_found && m_awvalid[cand]) begin
                arb_found = 1'b1;
                arb_pick  = cand;
            end
        end
    end

    // AW/W steering. Only the granted master sees a ready signal, and the
    // slave payload is held at zero outside the phase that uses it.
    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wlast   = 1'b0;
        case (state)
            ADDR: begin
                s_awvalid        = m_awvalid[grant];
                s_awaddr         = m_awaddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
                s_awlen          = m_awlen[grant*8 +: 8];
                m_awready[grant] = s_awready;
            end
            DATA: begin
                s_wvalid        = m_wvalid[grant];
                s_wdata         = m_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
                s_wlast         = m_wlast[grant];
                m_wready[grant] = s_wready;
            end
            default: ;
        endcase
    end

    // B steering runs independently of the AW/W state machine
    always_comb begin
        m_bvalid = '0;
        m_bresp  = '0;
        s_bready = 1'b0;
        if (!q_empty) begin
            m_bvalid[head]         = s_bvalid;
            m_bresp[head*2 +: 2]   = s_bresp;
            s_bready               = m_bready[head];
        end
    end

    // The queue is checked for space only in ARB. Between ARB and the push
    // in ADDR the queue can only shrink, so the push never overflows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            grant      <= '0;
            last_grant <= LAST_MST;
        end else begin
            case (state)
                ARB: begin
                    if (arb_found && !q_full) begin
                        grant <= arb_pick;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (push)
                        state <= DATA;
                end
                DATA: begin
                    // WLAST alone ends the burst; the beat count is not checked
                    if (s_wvalid && s_wready && s_wlast) begin
                        last_grant <= grant;
                        state      <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            wr_wrap <= 1'b0;
            rd_ptr  <= '0;
            rd_wrap <= 1'b0;
        end else begin
            if (push) begin
                if (wr_ptr == PTR_MAX) begin
                    wr_ptr  <= '0;
                    wr_wrap <= ~wr_wrap;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (pop) begin
                if (rd_ptr == PTR_MAX) begin
                    rd_ptr  <= '0;
                    rd_wrap <= ~rd_wrap;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Queue storage needs no reset; the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_ptr] <= grant;
    end

endmodule
